// File: rtl/tlp_rx_stream_arbiter.sv
// Packet-level arbiter draining two FWFT TLP-beat FIFOs into one AXI-Stream TX port.
// Whole packets are granted; filler/orphan beats are discarded and oversize packets truncated.
module tlp_rx_stream_arbiter #(
  parameter int CNT_W      = 8,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_BEATS  = 514
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             arb_en,
  input  logic [71:0]      src0_dout,
  input  logic             src0_empty,
  output logic             src0_rd_en,
  input  logic [71:0]      src1_dout,
  input  logic             src1_empty,
  output logic             src1_rd_en,
  output logic [63:0]      tx_tdata,
  output logic [7:0]       tx_tkeep,
  output logic             tx_tlast,
  output logic             tx_tvalid,
  input  logic             tx_tready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count0,
  output logic [CNT_W-1:0] pkt_count1,
  output logic [CNT_W-1:0] drop_count
);
  localparam int BC_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {ARB = 2'd0, PKT = 2'd1, SKIP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [63:0]      tdata_q, tdata_d;
  logic [7:0]       tkeep_q, tkeep_d;
  logic             tlast_q, tlast_d;
  logic             tvalid_q, tvalid_d;
  logic [CNT_W-1:0] pkt_count0_q, pkt_count0_d;
  logic [CNT_W-1:0] pkt_count1_q, pkt_count1_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic [7:0]       tag0, tag1, head_tag;
  logic [71:0]      head;
  logic             head_empty, out_free, req0, req1, sel;
  logic             disc0, disc1, pop, inc0, inc1;
  logic [1:0]       drops;
  logic [CNT_W+1:0] drop_sum;

  // Next-state, output-register and counter logic
  always_comb begin
    tag0       = src0_dout[71:64];
    tag1       = src1_dout[71:64];
    head       = grant_q ? src1_dout : src0_dout;
    head_tag   = head[71:64];
    head_empty = grant_q ? src1_empty : src0_empty;
    out_free   = !tvalid_q || tx_tready;
    req0       = !src0_empty && tag0[0];
    req1       = !src1_empty && tag1[0];
    if (FIXED_PRIO != 0) begin
      sel = !req0;
    end else if (req0 && req1) begin
      sel = !last_grant_q;
    end else begin
      sel = req1;
    end

    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tlast_d      = tlast_q;
    tvalid_d     = out_free ? 1'b0 : tvalid_q;
    disc0        = 1'b0;
    disc1        = 1'b0;
    pop          = 1'b0;
    inc0         = 1'b0;
    inc1         = 1'b0;
    drops        = 2'd0;

    case (state_q)
      ARB: begin
        if (arb_en) begin
          disc0 = !src0_empty && !tag0[0];
          disc1 = !src1_empty && !tag1[0];
          drops = {1'b0, disc0 && (tag0 != 8'd0)} + {1'b0, disc1 && (tag1 != 8'd0)};
          if (req0 || req1) begin
            grant_d    = sel;
            beat_cnt_d = '0;
            state_d    = PKT;
          end else begin
            state_d = ARB;
          end
        end else begin
          state_d = ARB;
        end
      end
      PKT: begin
        if (!head_empty && out_free) begin
          pop = 1'b1;
          if (head_tag != 8'd0) begin
            tvalid_d   = 1'b1;
            tdata_d    = head[63:0];
            tkeep_d    = {{4{head_tag[3]}}, {4{head_tag[2]}}};
            beat_cnt_d = beat_cnt_q + BC_W'(1);
            inc0       = !grant_q && (head_tag[1] || (beat_cnt_q == BC_W'(MAX_BEATS - 1)));
            inc1       = grant_q && (head_tag[1] || (beat_cnt_q == BC_W'(MAX_BEATS - 1)));
            if (head_tag[1]) begin
              tlast_d      = 1'b1;
              last_grant_d = grant_q;
              state_d      = ARB;
            end else if (beat_cnt_q == BC_W'(MAX_BEATS - 1)) begin
              // Oversize: close the packet downstream, then drain the rest in SKIP
              tlast_d = 1'b1;
              drops   = 2'd1;
              state_d = SKIP;
            end else begin
              tlast_d = 1'b0;
            end
          end else begin
            state_d = PKT;
          end
        end else begin
          state_d = PKT;
        end
      end
      SKIP: begin
        if (!head_empty) begin
          pop = 1'b1;
          if (head_tag[1]) begin
            last_grant_d = grant_q;
            state_d      = ARB;
          end else begin
            state_d = SKIP;
          end
        end else begin
          state_d = SKIP;
        end
      end
      default: state_d = ARB;
    endcase

    pkt_count0_d = pkt_count0_q + CNT_W'(inc0);
    pkt_count1_d = pkt_count1_q + CNT_W'(inc1);
    drop_sum     = {2'b00, drop_count_q} + (CNT_W + 2)'(drops);
    if (drop_sum > {2'b00, {CNT_W{1'b1}}}) begin
      drop_count_d = {CNT_W{1'b1}};
    end else begin
      drop_count_d = drop_sum[CNT_W-1:0];
    end
  end

  assign src0_rd_en = sys_rst_n && (disc0 || (pop && !grant_q));
  assign src1_rd_en = sys_rst_n && (disc1 || (pop && grant_q));

  // State and output registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ARB;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      tdata_q      <= 64'd0;
      tkeep_q      <= 8'd0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      pkt_count0_q <= '0;
      pkt_count1_q <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
      pkt_count0_q <= pkt_count0_d;
      pkt_count1_q <= pkt_count1_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign tx_tdata   = tdata_q;
  assign tx_tkeep   = tkeep_q;
  assign tx_tlast   = tlast_q;
  assign tx_tvalid  = tvalid_q;
  assign busy       = (state_q != ARB);
  assign pkt_count0 = pkt_count0_q;
  assign pkt_count1 = pkt_count1_q;
  assign drop_count = drop_count_q;
endmodule
